gradient_generator: RTL

- Streaming first-gradient (G1) engine for the style-transfer video path.
- Sits directly upstream of the boundary filter and produces the per-channel gradient RGB it consumes.
- Consumes one raster-order RGB pixel per valid cycle and keeps a one-line buffer of the previous row.
- Emits |horizontal diff| + |vertical diff| per channel, saturated to 8 bits, with fixed 2-cycle latency.

---
 rtl/gradient_generator.sv | 122 ++++++++++++
 1 files changed

// File: rtl/gradient_generator.sv
// rtl/gradient_generator.sv - streaming |dx|+|dy| gradient engine with one-line buffer, 2-cycle latency.
// Optional macro GRAD_GRAY_EN: compute a single luma gradient and drive it on all three outputs.
module gradient_generator #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       iValid,
    input  logic       iFrameStart,
    input  logic [7:0] iRed,
    input  logic [7:0] iGreen,
    input  logic [7:0] iBlue,
    output logic       oValid,
    output logic [7:0] oRed_G1,
    output logic [7:0] oGreen_G1,
    output logic [7:0] oBlue_G1
);

`ifdef GRAD_GRAY_EN
    localparam int NCH = 1;
`else
    localparam int NCH = 3;
`endif
    localparam int PW = 8 * NCH;
    localparam int CW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
    localparam int RW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;

    logic [CW-1:0] colCnt, curCol;
    logic [RW-1:0] rowCnt, curRow;
    logic [PW-1:0] curPix, leftReg, pix1, left1, above1;
    logic [PW-1:0] lineBuf [H_ACTIVE];
    logic          valid1, colZero1, rowZero1;

`ifdef GRAD_GRAY_EN
    logic [9:0] ySum;
    logic [9:0] yQuot;
    assign ySum   = {2'b00, iRed} + {2'b00, iGreen} + {2'b00, iBlue};
    assign yQuot  = ySum / 10'd3;
    assign curPix = yQuot[7:0];
`else
    assign curPix = {iRed, iGreen, iBlue};
`endif

    // A frame-start pixel is (0,0) no matter where the counters had drifted to.
    always_comb begin
        curCol = iFrameStart ? '0 : colCnt;
        curRow = iFrameStart ? '0 : rowCnt;
    end

    function automatic logic [7:0] gradOf(input logic [7:0] p, input logic [7:0] l,
                                          input logic [7:0] a, input logic cz, input logic rz);
        logic [7:0] dx;
        logic [7:0] dy;
        logic [8:0] s;
        dx = cz ? 8'd0 : ((p > l) ? (p - l) : (l - p));
        dy = rz ? 8'd0 : ((p > a) ? (p - a) : (a - p));
        s  = {1'b0, dx} + {1'b0, dy};
        return s[8] ? 8'hFF : s[7:0];
    endfunction

    // Buffer contents are never reset; row-0 masking hides stale entries.
    always_ff @(posedge i_clk) begin
        if (iValid) begin
            lineBuf[curCol] <= curPix;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            colCnt   <= '0;
            rowCnt   <= '0;
            leftReg  <= '0;
            pix1     <= '0;
            left1    <= '0;
            above1   <= '0;
            colZero1 <= 1'b0;
            rowZero1 <= 1'b0;
            valid1   <= 1'b0;
        end else begin
            valid1 <= iValid;
            if (iValid) begin
                pix1     <= curPix;
                left1    <= leftReg;
                above1   <= lineBuf[curCol];
                colZero1 <= (curCol == '0);
                rowZero1 <= (curRow == '0);
                leftReg  <= curPix;
                if (curCol == CW'(H_ACTIVE - 1)) begin
                    colCnt <= '0;
                    rowCnt <= (curRow == RW'(V_ACTIVE - 1)) ? '0 : curRow + 1'b1;
                end else begin
                    colCnt <= curCol + 1'b1;
                    rowCnt <= curRow;
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            oValid    <= 1'b0;
            oRed_G1   <= 8'd0;
            oGreen_G1 <= 8'd0;
            oBlue_G1  <= 8'd0;
        end else begin
            oValid <= valid1;
            if (valid1) begin
`ifdef GRAD_GRAY_EN
                oRed_G1   <= gradOf(pix1, left1, above1, colZero1, rowZero1);
                oGreen_G1 <= gradOf(pix1, left1, above1, colZero1, rowZero1);
                oBlue_G1  <= gradOf(pix1, left1, above1, colZero1, rowZero1);
`else
                oRed_G1   <= gradOf(pix1[23:16], left1[23:16], above1[23:16], colZero1, rowZero1);
                oGreen_G1 <= gradOf(pix1[15:8], left1[15:8], above1[15:8], colZero1, rowZero1);
                oBlue_G1  <= gradOf(pix1[7:0], left1[7:0], above1[7:0], colZero1, rowZero1);
`endif
            end
        end
    end

endmodule
